// File: rtl/soc_system_pio_gpio_pkg.sv
`default_nettype none
// ============================================================================
// soc_system_pio_gpio_pkg : register map and edge-type encodings for the GPIO
// Revision: 1.0
// ============================================================================
package soc_system_pio_gpio_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage
`default_nettype wire

// File: rtl/soc_system_pio_gpio_sync.sv
`default_nettype none
// ============================================================================
// soc_system_pio_gpio_sync : multi-flop input synchroniser, async reset
// Revision: 1.0
// ============================================================================
module soc_system_pio_gpio_sync
    import soc_system_pio_gpio_pkg::*;
#(
    parameter int DATA_WIDTH  = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] async_in,
    output logic [DATA_WIDTH-1:0] sync_out
);

    // Stage 0 samples the pins; the top entry is the synchronised value.
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/soc_system_pio_gpio.sv
`default_nettype none
// ============================================================================
// soc_system_pio_gpio : Avalon-MM bidirectional GPIO with edge capture and irq
// Revision: 1.0
// ============================================================================
module soc_system_pio_gpio
    import soc_system_pio_gpio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 10,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '1,
    parameter logic [DATA_WIDTH-1:0] RESET_DIR   = '1,
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe,
    output logic                  irq
);

    localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] data_out, dir, mask, cap, prev, in_sync;
    logic [DATA_WIDTH-1:0] data_next, dir_next, mask_next, cap_next;
    logic [DATA_WIDTH-1:0] wd, clr, edge_det, read_val;
    logic [2:0]            arm_cnt;
    logic                  armed, wr;
    logic                  unused_writedata;

    assign wr               = chipselect & ~write_n;
    assign wd               = writedata[DATA_WIDTH-1:0];
    assign unused_writedata = ^writedata;
    assign armed            = (arm_cnt == ARM_CYCLES);

    soc_system_pio_gpio_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(in_port),
        .sync_out(in_sync)
    );

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALLING: edge_det = ~in_sync & prev;
            EDGE_ANY:     edge_det = in_sync ^ prev;
            default:      edge_det = in_sync & ~prev;
        endcase
    end

    always_comb begin
        data_next = data_out;
        dir_next  = dir;
        mask_next = mask;
        clr       = '0;
        if (wr) begin
            case (address)
                ADDR_DATA: data_next = wd;
                ADDR_DIR:  dir_next  = wd;
                ADDR_MASK: mask_next = wd;
                ADDR_EDGE: clr       = wd;
                ADDR_SET:  data_next = data_out | wd;
                ADDR_CLR:  data_next = data_out & ~wd;
                default:   ;
            endcase
        end
        // A fresh edge takes precedence over a same-cycle clear of that bit.
        cap_next = (cap & ~clr) | (edge_det & {DATA_WIDTH{armed}});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RESET_VALUE;
            dir      <= RESET_DIR;
            mask     <= '0;
            cap      <= '0;
            prev     <= '0;
            arm_cnt  <= '0;
            irq      <= 1'b0;
        end else begin
            data_out <= data_next;
            dir      <= dir_next;
            mask     <= mask_next;
            cap      <= cap_next;
            prev     <= in_sync;
            irq      <= |(cap_next & mask_next);
            if (!armed) begin
                arm_cnt <= arm_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        read_val = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA: read_val = (dir & data_out) | (~dir & in_sync);
                ADDR_DIR:  read_val = dir;
                ADDR_MASK: read_val = mask;
                ADDR_EDGE: read_val = cap;
                default:   read_val = '0;
            endcase
        end
        readdata                 = '0;
        readdata[DATA_WIDTH-1:0] = read_val;
    end

    assign out_port = data_out;
    assign oe       = dir;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pio_gpio.sv
`default_nettype none
// ============================================================================
// tb_soc_system_pio_gpio : directed and randomised checks against a pin-history model
// Revision: 1.0
// ============================================================================
module tb_soc_system_pio_gpio;
    import soc_system_pio_gpio_pkg::*;

    localparam int DW = 10;
    localparam int S  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [DW-1:0] in_port = '0;
    logic [DW-1:0] out_port;
    logic [DW-1:0] oe;
    logic          irq;

    always #5 clk = ~clk;

    soc_system_pio_gpio #(
        .DATA_WIDTH (DW),
        .RESET_VALUE('1),
        .RESET_DIR  ('1),
        .EDGE_TYPE  (EDGE_RISING),
        .SYNC_STAGES(S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .oe        (oe),
        .irq       (irq)
    );

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Reference state; pins[k] is the pin value sampled at the k-th edge after reset.
    logic [DW-1:0] m_data, m_dir, m_mask, m_cap;
    logic          m_irq;
    int            n;
    logic [DW-1:0] pins[$];

    function automatic logic [DW-1:0] sync_at(int k);
        int idx;
        idx = k - S + 1;
        if (idx >= 1 && idx < pins.size()) return pins[idx];
        return '0;
    endfunction

    function automatic logic [31:0] m_read(logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r[DW-1:0] = (m_dir & m_data) | (~m_dir & sync_at(n));
            3'd1: r[DW-1:0] = m_dir;
            3'd2: r[DW-1:0] = m_mask;
            3'd3: r[DW-1:0] = m_cap;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_data = '1; m_dir = '1; m_mask = '0; m_cap = '0; m_irq = 1'b0;
        n = 0;
        pins.delete();
        pins.push_back('0);
    endtask

    task automatic model_edge();
        logic [DW-1:0] cur, prv, rise, wdv, clrv;
        cur  = sync_at(n);
        prv  = sync_at(n - 1);
        rise = cur & ~prv;
        wdv  = writedata[DW-1:0];
        clrv = '0;
        if (chipselect && !write_n) begin
            case (address)
                ADDR_DATA: m_data = wdv;
                ADDR_DIR:  m_dir  = wdv;
                ADDR_MASK: m_mask = wdv;
                ADDR_EDGE: clrv   = wdv;
                ADDR_SET:  m_data = m_data | wdv;
                ADDR_CLR:  m_data = m_data & ~wdv;
                default:   ;
            endcase
        end
        m_cap = (m_cap & ~clrv) | ((n >= S + 1) ? rise : '0);
        m_irq = |(m_cap & m_mask);
        pins.push_back(in_port);
        n++;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [2:0] a, logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(string tag, logic [2:0] a, logic [31:0] exp);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        check(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic check_model(string tag);
        check({tag, "_out"}, 32'(out_port), 32'(m_data));
        check({tag, "_oe"},  32'(oe),       32'(m_dir));
        check({tag, "_irq"}, 32'(irq),      32'(m_irq));
    endtask

    task automatic async_reset_pulse();
        reset = 1'b1;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        logic [2:0]  a;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_port", 32'(out_port), 32'h3FF);
        check("rst_oe",       32'(oe),       32'h3FF);
        check("rst_irq",      32'(irq),      32'h0);
        check("rst_rd_idle",  readdata,      32'h0);
        rd("rst_data", 3'd0, 32'h3FF);
        rd("rst_dir",  3'd1, 32'h3FF);
        rd("rst_mask", 3'd2, 32'h0);
        rd("rst_cap",  3'd3, 32'h0);
        step();

        // Direction split and input readback
        wr(ADDR_DIR, 32'h0F0);
        wr(ADDR_CLR, 32'h0FF);
        check("dir_out_port", 32'(out_port), 32'h300);
        check("dir_oe",       32'(oe),       32'h0F0);
        in_port = 10'h00A;
        repeat (S + 1) step();
        rd("data_mixed", 3'd0, 32'h00A);
        check_model("mixed");

        // Pin already high at reset release must not be captured
        reset = 1'b1;
        in_port = 10'h008;
        #1;
        model_reset();
        check("rst2_out_port", 32'(out_port), 32'h3FF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) step();
        rd("arm_suppress", 3'd3, 32'h0);

        // Rising edge on bit 2 with mask exposing it
        wr(ADDR_MASK, 32'h004);
        in_port = 10'h00C;
        repeat (3) step();
        rd("edge_cap", 3'd3, 32'h004);
        step();
        check("edge_irq", 32'(irq), 32'h1);
        wr(ADDR_EDGE, 32'h004);
        check("clr_irq", 32'(irq), 32'h0);
        rd("clr_cap", 3'd3, 32'h0);
        check_model("clr");

        // Clear colliding with a new edge: the edge wins
        in_port = 10'h008;
        repeat (S + 2) step();
        in_port = 10'h00C;
        repeat (S + 1) step();
        check_model("recap");
        in_port = 10'h008;
        repeat (S + 2) step();
        in_port = 10'h00C;
        repeat (S) step();
        wr(ADDR_EDGE, 32'h004);
        rd("collide_cap", 3'd3, 32'h004);
        check("collide_irq", 32'(irq), 32'h1);

        // Reset in the middle of activity
        wr(ADDR_CLR, 32'h3FF);
        wr(ADDR_SET, 32'h055);
        wr(ADDR_MASK, 32'h3FF);
        check("burst_out_port", 32'(out_port), 32'h055);
        check("burst_irq",      32'(irq),      32'h1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("mid_rst_out_port", 32'(out_port), 32'h3FF);
        check("mid_rst_irq",      32'(irq),      32'h0);
        @(posedge clk);
        #1;
        in_port = '0;
        reset = 1'b0;

        // Unmapped addresses
        rd("rd_addr6", 3'd6, 32'h0);
        rd("rd_addr7", 3'd7, 32'h0);
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'h0000_0000);
        rd("after67_data", 3'd0, 32'h3FF);
        rd("after67_dir",  3'd1, 32'h3FF);
        rd("after67_mask", 3'd2, 32'h0);
        step();
        check("after67_out_port", 32'(out_port), 32'h3FF);
        check("after67_irq",      32'(irq),      32'h0);

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            in_port = r[DW-1:0];
            if ($urandom_range(0, 99) == 0) begin
                async_reset_pulse();
            end else if ($urandom_range(0, 1) == 0) begin
                r = $urandom;
                a = r[2:0];
                r = $urandom;
                // Bias writes toward sparse patterns so clears and masks interact
                if (a == ADDR_MASK || a == ADDR_EDGE) r = r & $urandom;
                wr(a, r);
            end else begin
                step();
            end
            check_model("rand");
            r = $urandom;
            a = r[2:0];
            rd("rand_rd", a, m_read(a));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
